d_cache_mem_bridge: RTL

D_CACHE_MEM_BRIDGE -- requirements
Module: d_cache_mem_bridge

---
 rtl/d_cache_pkg.sv | 17 +
 rtl/d_cache_mem_bridge_if.sv | 38 +++
 rtl/d_cache_wr_buffer.sv | 44 ++++
 rtl/d_cache_mem_bridge.sv | 113 +++++++++++
 4 files changed

// File: rtl/d_cache_pkg.sv
// Shared definitions for the cache/memory bridge: FSM state codes and beat-counter sizing.
package d_cache_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int NUMBER_WORD_DEF = 4;
    localparam int BEAT_W          = $clog2(NUMBER_WORD_DEF);

    // Beat counter width for a given line size (log2 of words per line).
    function automatic int beat_w(input int number_word);
        return (number_word < 2) ? 1 : $clog2(number_word);
    endfunction

endpackage

// File: rtl/d_cache_mem_bridge_if.sv
// Cache-side and memory-side bundle of the bridge; slave = bridge view, master = cache + memory view.
interface d_cache_mem_bridge_if #(
    parameter int Width_Data  = 32,
    parameter int NUMBER_WORD = 4,
    parameter int Width_ADD   = 32
);
    logic                              RD_EN_MEM;
    logic [Width_ADD-1:0]              Line_ADD;
    logic                              WR_EN_MEM;
    logic [Width_ADD-1:0]              Write_ADD_MEM;
    logic [Width_Data-1:0]             Write_Data_MEM;
    logic [Width_Data/8-1:0]           Write_Strb;
    logic [Width_Data*NUMBER_WORD-1:0] Data_RD_MEM;
    logic                              RD_Valid_MEM;
    logic                              Write_ready_MEM;

    logic [Width_ADD-1:0]              M_ADD;
    logic                              M_RD_REQ;
    logic                              M_WR_REQ;
    logic [Width_Data-1:0]             M_WDATA;
    logic [Width_Data/8-1:0]           M_STRB;
    logic [Width_Data-1:0]             M_RDATA;
    logic                              M_ACK;

    modport slave (
        input  RD_EN_MEM, Line_ADD, WR_EN_MEM, Write_ADD_MEM, Write_Data_MEM, Write_Strb,
        input  M_RDATA, M_ACK,
        output Data_RD_MEM, RD_Valid_MEM, Write_ready_MEM,
        output M_ADD, M_RD_REQ, M_WR_REQ, M_WDATA, M_STRB
    );

    modport master (
        output RD_EN_MEM, Line_ADD, WR_EN_MEM, Write_ADD_MEM, Write_Data_MEM, Write_Strb,
        output M_RDATA, M_ACK,
        input  Data_RD_MEM, RD_Valid_MEM, Write_ready_MEM,
        input  M_ADD, M_RD_REQ, M_WR_REQ, M_WDATA, M_STRB
    );
endinterface

// File: rtl/d_cache_wr_buffer.sv
// Single-entry write-through buffer; push visible next cycle (o_full), pop frees it next cycle.
// Backpressure: pushes while full are dropped, the owner advertises ready = ~o_full.
module d_cache_wr_buffer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            i_push,
    input  logic [AW-1:0]   i_add,
    input  logic [DW-1:0]   i_data,
    input  logic [DW/8-1:0] i_strb,
    input  logic            i_pop,
    output logic            o_full,
    output logic [AW-1:0]   o_add,
    output logic [DW-1:0]   o_data,
    output logic [DW/8-1:0] o_strb
);
    logic            r_full;
    logic [AW-1:0]   r_add;
    logic [DW-1:0]   r_data;
    logic [DW/8-1:0] r_strb;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_full <= 1'b0;
            r_add  <= '0;
            r_data <= '0;
            r_strb <= '0;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end else if (i_push && !r_full) begin
            r_full <= 1'b1;
            r_add  <= i_add;
            r_data <= i_data;
            r_strb <= i_strb;
        end
    end

    assign o_full = r_full;
    assign o_add  = r_add;
    assign o_data = r_data;
    assign o_strb = r_strb;
endmodule

// File: rtl/d_cache_mem_bridge.sv
// Bridges cache line refills and write-throughs onto a single-beat memory port; one beat per M_ACK.
// Backpressure: memory stalls by withholding M_ACK; cache writes are held off by Write_ready_MEM.
module d_cache_mem_bridge
    import d_cache_pkg::*;
#(
    parameter int Width_Data  = 32,
    parameter int NUMBER_WORD = 4,
    parameter int Width_ADD   = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    d_cache_mem_bridge_if.slave  io_bus
);
    localparam int CNT_W  = beat_w(NUMBER_WORD);
    localparam int STRB_W = Width_Data / 8;
    localparam int TAG_W  = Width_ADD - CNT_W - 2;

    logic [1:0]                        r_state;
    logic [CNT_W-1:0]                  r_cnt;
    logic [TAG_W-1:0]                  r_tag;
    logic [Width_Data*NUMBER_WORD-1:0] r_line;

    logic                  w_buf_full;
    logic                  w_wr_cap;
    logic                  w_wr_pop;
    logic                  w_last;
    logic [Width_ADD-1:0]  w_buf_add;
    logic [Width_Data-1:0] w_buf_data;
    logic [STRB_W-1:0]     w_buf_strb;
    logic [Width_ADD-1:0]  w_m_add;
    logic [Width_Data-1:0] w_m_wdata;
    logic [STRB_W-1:0]     w_m_strb;
    logic                  w_unused_line_lsb;

    assign w_wr_cap = io_bus.WR_EN_MEM & ~w_buf_full;
    assign w_wr_pop = (r_state == ST_WRITE) & io_bus.M_ACK;
    assign w_last   = (r_cnt == CNT_W'(NUMBER_WORD - 1));
    assign w_unused_line_lsb = ^io_bus.Line_ADD[CNT_W+1:0];

    d_cache_wr_buffer #(
        .AW (Width_ADD),
        .DW (Width_Data)
    ) u_wr_buffer (
        .CLK    (CLK),
        .RST    (RST),
        .i_push (w_wr_cap),
        .i_add  (io_bus.Write_ADD_MEM),
        .i_data (io_bus.Write_Data_MEM),
        .i_strb (io_bus.Write_Strb),
        .i_pop  (w_wr_pop),
        .o_full (w_buf_full),
        .o_add  (w_buf_add),
        .o_data (w_buf_data),
        .o_strb (w_buf_strb)
    );

    // A write captured this cycle goes out before any refill, keeping read-after-write order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_buf_full || w_wr_cap) begin
                        r_state <= ST_WRITE;
                    end else if (io_bus.RD_EN_MEM) begin
                        r_tag   <= io_bus.Line_ADD[Width_ADD-1:CNT_W+2];
                        r_cnt   <= '0;
                        r_state <= ST_REFILL;
                    end
                end
                ST_WRITE: begin
                    if (io_bus.M_ACK) r_state <= ST_IDLE;
                end
                ST_REFILL: begin
                    if (io_bus.M_ACK) begin
                        r_line[r_cnt*Width_Data +: Width_Data] <= io_bus.M_RDATA;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_m_add   = '0;
        w_m_wdata = '0;
        w_m_strb  = '0;
        case (r_state)
            ST_WRITE: begin
                w_m_add   = w_buf_add;
                w_m_wdata = w_buf_data;
                w_m_strb  = w_buf_strb;
            end
            ST_REFILL: w_m_add = {r_tag, r_cnt, 2'b00};
            default: ;
        endcase
    end

    assign io_bus.M_ADD           = w_m_add;
    assign io_bus.M_WDATA         = w_m_wdata;
    assign io_bus.M_STRB          = w_m_strb;
    assign io_bus.M_RD_REQ        = (r_state == ST_REFILL);
    assign io_bus.M_WR_REQ        = (r_state == ST_WRITE);
    assign io_bus.RD_Valid_MEM    = (r_state == ST_DONE);
    assign io_bus.Write_ready_MEM = ~w_buf_full;
    assign io_bus.Data_RD_MEM     = r_line;
endmodule
